// File: rtl/control_pkg.sv
// Shared control types for the vgacpu sequencer, fetch unit and decoder.
package control_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    MEM_RD  = 3'd3,
    MEM_WR  = 3'd4,
    EXECUTE = 3'd5,
    HALT    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    MC_NONE  = 2'b00,
    MC_READ  = 2'b01,
    MC_WRITE = 2'b10,
    MC_HALT  = 2'b11
  } mem_class_t;

  // State entered when DECODE completes, chosen by the decoded memory class.
  function automatic state_t class_target(input mem_class_t mc);
    state_t target;
    case (mc)
      MC_READ:  target = MEM_RD;
      MC_WRITE: target = MEM_WR;
      MC_HALT:  target = HALT;
      default:  target = EXECUTE;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the control sequencer and the fetch unit,
// decoder, data-memory port and datapath.
interface control_sequencer_if #(
  parameter int FETCH_WORDS_MAX = 3,
  parameter int EXEC_CNT_W      = 4,
  parameter int IDX_W           = $clog2(FETCH_WORDS_MAX + 1)
);

  logic                  stall;
  logic                  fetch_valid;
  logic [IDX_W-1:0]      instr_len;
  logic [1:0]            mem_class;
  logic [EXEC_CNT_W-1:0] exec_cycles;
  logic                  mem_ack;

  logic                  fetch_req;
  logic [IDX_W-1:0]      fetch_word_idx;
  logic                  ir_load;
  logic                  pc_inc;
  logic                  mem_req;
  logic                  mem_we;
  logic                  rf_we;
  logic                  halted;

  modport master (
    input  stall, fetch_valid, instr_len, mem_class, exec_cycles, mem_ack,
    output fetch_req, fetch_word_idx, ir_load, pc_inc, mem_req, mem_we, rf_we, halted
  );

  modport slave (
    output stall, fetch_valid, instr_len, mem_class, exec_cycles, mem_ack,
    input  fetch_req, fetch_word_idx, ir_load, pc_inc, mem_req, mem_we, rf_we, halted
  );

endinterface

// File: rtl/ctrl_down_counter.sv
// Loadable down counter with a zero flag; it saturates at zero instead of wrapping.
module ctrl_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_sync,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control FSM for the vgacpu core: variable-length fetch, decode,
// handshaked data access, variable-length execute, global stall and terminal halt.
module control_sequencer
  import control_pkg::*;
#(
  parameter int FETCH_WORDS_MAX = 3,
  parameter int EXEC_CNT_W      = 4
) (
  input  logic                clk,
  input  logic                rst_sync,
  control_sequencer_if.master bus,
  output state_t              state_o
);

  localparam int IDX_W = $clog2(FETCH_WORDS_MAX + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] first_len, cur_len;
  logic             accept, last_word;
  logic             cnt_load, cnt_dec, cnt_zero;

  logic             fetch_req, ir_load, mem_req, mem_we, rf_we, halted;
  logic [IDX_W-1:0] word_idx;

  // A zero length still fetches one word; over-long lengths are cut to the IR size.
  function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] raw);
    logic [IDX_W-1:0] res;
    res = raw;
    if (raw == '0) begin
      res = IDX_W'(1);
    end else if (raw > IDX_W'(FETCH_WORDS_MAX)) begin
      res = IDX_W'(FETCH_WORDS_MAX);
    end
    return res;
  endfunction

  // Word 0 has to use the decoder's length directly, before it is latched.
  assign accept    = (state_q == FETCH) && bus.fetch_valid && !bus.stall;
  assign first_len = clamp_len(bus.instr_len);
  assign cur_len   = (idx_q == '0) ? first_len : len_q;
  assign last_word = (idx_q == (cur_len - IDX_W'(1)));

  ctrl_down_counter #(
    .W(EXEC_CNT_W)
  ) u_exec_cnt (
    .clk      (clk),
    .rst_sync (rst_sync),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (bus.exec_cycles),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      INIT: state_d = FETCH;
      FETCH: begin
        if (accept) begin
          if (idx_q == '0) begin
            len_d = first_len;
          end
          if (last_word) begin
            state_d = DECODE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DECODE: begin
        if (!bus.stall) begin
          cnt_load = 1'b1;
          state_d  = class_target(mem_class_t'(bus.mem_class));
        end
      end
      // Memory accesses run to completion regardless of stall.
      MEM_RD, MEM_WR: begin
        if (bus.mem_ack) begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        if (!bus.stall) begin
          if (cnt_zero) begin
            state_d = FETCH;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      HALT: state_d = HALT;
      default: begin
        state_d = INIT;
        idx_d   = '0;
        len_d   = '0;
      end
    endcase
  end

  always_comb begin
    fetch_req = 1'b0;
    word_idx  = '0;
    ir_load   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_req = 1'b1;
        word_idx  = idx_q;
        ir_load   = accept;
      end
      MEM_RD: mem_req = 1'b1;
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      EXECUTE: rf_we = !bus.stall && cnt_zero;
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q <= INIT;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

  assign bus.fetch_req      = fetch_req;
  assign bus.fetch_word_idx = word_idx;
  assign bus.ir_load        = ir_load;
  assign bus.pc_inc         = ir_load;
  assign bus.mem_req        = mem_req;
  assign bus.mem_we         = mem_we;
  assign bus.rf_we          = rf_we;
  assign bus.halted         = halted;
  assign state_o            = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver plays fetch unit, decoder and
// data memory and queues expected events; an independent monitor pops and compares them.
module tb_control_sequencer;
  import control_pkg::*;

  localparam int MAX_WORDS = 3;
  localparam int EXEC_W    = 4;
  localparam int IDX_W     = $clog2(MAX_WORDS + 1);
  localparam int EV_IR     = 0;
  localparam int EV_MEM    = 1;
  localparam int EV_RF     = 2;
  localparam int EV_HALT   = 3;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic   clk = 1'b0;
  logic   rst_sync;
  state_t state_o;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  int  mem_cyc, ex_act, ex_tot;
  bit  halt_prev;

  control_sequencer_if #(.FETCH_WORDS_MAX(MAX_WORDS), .EXEC_CNT_W(EXEC_W)) bus ();

  control_sequencer #(
    .FETCH_WORDS_MAX (MAX_WORDS),
    .EXEC_CNT_W      (EXEC_W)
  ) dut (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (bus),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: DUT event did not arrive within budget at time %0t", name, $time);
  endtask

  task automatic popExpect(output ev_t e);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e = '{-1, -1, -1};
    end
  endtask

  function automatic int outVec();
    return int'({bus.fetch_req, bus.fetch_word_idx, bus.ir_load, bus.pc_inc,
                 bus.mem_req, bus.mem_we, bus.rf_we, bus.halted});
  endfunction

  // Monitor: every observed strobe consumes the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_sync || !mon_en) begin
        mem_cyc   = 0;
        ex_act    = 0;
        ex_tot    = 0;
        halt_prev = 1'b0;
      end else begin
        if (bus.ir_load) begin
          popExpect(e);
          checkOutput("ir_load_event", EV_IR, e.kind);
          checkOutput("ir_word_idx", int'(bus.fetch_word_idx), e.a);
          checkOutput("pc_inc_with_ir_load", int'(bus.pc_inc), 1);
        end
        if (bus.mem_req) begin
          mem_cyc++;
          if (bus.mem_ack) begin
            popExpect(e);
            checkOutput("mem_event", EV_MEM, e.kind);
            checkOutput("mem_we", int'(bus.mem_we), e.a);
            checkOutput("mem_req_cycles", mem_cyc, e.b);
            mem_cyc = 0;
          end
        end
        if (state_o == EXECUTE) begin
          ex_tot++;
          if (!bus.stall) ex_act++;
        end
        if (bus.rf_we) begin
          popExpect(e);
          checkOutput("rf_we_event", EV_RF, e.kind);
          checkOutput("exec_active_cycles", ex_act, e.a);
          if (e.b >= 0) checkOutput("exec_total_cycles", ex_tot, e.b);
          ex_act = 0;
          ex_tot = 0;
        end
        if (bus.halted) begin
          if (!halt_prev) begin
            popExpect(e);
            checkOutput("halt_event", EV_HALT, e.kind);
          end
          checkOutput("halt_strobes_quiet",
                      int'({bus.fetch_req, bus.ir_load, bus.pc_inc, bus.mem_req, bus.mem_we, bus.rf_we}), 0);
        end
        halt_prev = bus.halted;
      end
    end
  end

  // Reset with busy inputs, then check INIT is silent for one cycle before FETCH.
  task automatic doReset();
    rst_sync        = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.stall       = 1'b0;
    bus.mem_ack     = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    checkOutput("reset_state", int'(state_o), int'(INIT));
    rst_sync = 1'b0;
    @(negedge clk);
    checkOutput("init_outputs_quiet", outVec(), 0);
    checkOutput("init_state_held", int'(state_o), int'(INIT));
    @(posedge clk); #1;
    checkOutput("init_to_fetch", int'(state_o), int'(FETCH));
    bus.fetch_valid = 1'b0;
    bus.mem_ack     = 1'b0;
  endtask

  // Runs one instruction to completion; expectations come from the instruction rules alone.
  task automatic applyStimulus(input int len, input int cls, input int ex, input int ack_delay,
                               input int valid_pct, input int stall_pct, input int exec_stalls);
    int  port_len, eff_len, mem_cnt, ex_seen, budget;
    bit  done, toggle;
    port_len = len % (1 << IDX_W);
    eff_len  = (port_len == 0) ? 1 : ((port_len > MAX_WORDS) ? MAX_WORDS : port_len);
    for (int i = 0; i < eff_len; i++) sb.push_back('{EV_IR, i, 0});
    if (cls == 1 || cls == 2) sb.push_back('{EV_MEM, (cls == 2) ? 1 : 0, ack_delay + 1});
    if (cls == 3) sb.push_back('{EV_HALT, 0, 0});
    else sb.push_back('{EV_RF, ex + 1, (stall_pct == 0) ? ex + 1 + exec_stalls : -1});
    bus.instr_len   = IDX_W'(port_len);
    bus.mem_class   = 2'(cls);
    bus.exec_cycles = EXEC_W'(ex);
    done    = 1'b0;
    toggle  = 1'b1;
    mem_cnt = 0;
    ex_seen = 0;
    budget  = 0;
    while (!done && budget < 400) begin
      if (state_o == EXECUTE && exec_stalls > 0) begin
        bus.stall = (ex_seen >= 2) && (ex_seen < 2 + exec_stalls);
        ex_seen++;
      end else begin
        bus.stall = (int'($urandom_range(99)) < stall_pct);
      end
      if (valid_pct < 0) begin
        bus.fetch_valid = toggle;
        toggle          = !toggle;
      end else begin
        bus.fetch_valid = (int'($urandom_range(99)) < valid_pct);
      end
      if (bus.mem_req) begin
        bus.mem_ack = (mem_cnt == ack_delay);
        mem_cnt++;
      end else begin
        bus.mem_ack = 1'b0;
        mem_cnt     = 0;
      end
      @(negedge clk);
      done = bus.rf_we || bus.halted;
      @(posedge clk); #1;
      budget++;
    end
    bus.mem_ack = 1'b0;
    if (!done) begin
      reportTimeout("instruction_timeout");
      doReset();
    end
  endtask

  task automatic holdHalt();
    repeat (20) begin
      bus.fetch_valid = 1'($urandom_range(1));
      bus.stall       = 1'($urandom_range(1));
      bus.mem_ack     = 1'($urandom_range(1));
      @(negedge clk);
      checkOutput("halted_held", int'(bus.halted), 1);
      @(posedge clk); #1;
    end
    checkOutput("halt_state_absorbing", int'(state_o), int'(HALT));
  endtask

  // Reset must abandon a write in progress even while ack and stall are asserted.
  task automatic checkResetMidWrite();
    int guard;
    sb.push_back('{EV_IR, 0, 0});
    bus.instr_len   = IDX_W'(1);
    bus.mem_class   = 2'(MC_WRITE);
    bus.exec_cycles = '0;
    bus.fetch_valid = 1'b1;
    bus.stall       = 1'b0;
    bus.mem_ack     = 1'b0;
    guard = 0;
    while (state_o != MEM_WR && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("reach_mem_wr", int'(state_o), int'(MEM_WR));
    repeat (2) begin
      @(negedge clk);
      checkOutput("mem_wr_req_held", int'({bus.mem_req, bus.mem_we}), 3);
      @(posedge clk); #1;
    end
    rst_sync    = 1'b1;
    bus.mem_ack = 1'b1;
    bus.stall   = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_mid_write_state", int'(state_o), int'(INIT));
    @(negedge clk);
    checkOutput("reset_mid_write_mem_req", int'(bus.mem_req), 0);
    checkOutput("reset_mid_write_outputs", outVec(), 0);
    rst_sync        = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.stall       = 1'b0;
    bus.fetch_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_sync        = 1'b1;
    bus.stall       = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.instr_len   = '0;
    bus.mem_class   = '0;
    bus.exec_cycles = '0;
    bus.mem_ack     = 1'b0;
    doReset();
    mon_en = 1'b1;

    applyStimulus(1, 0, 0, 0, 100, 0, 0);
    applyStimulus(3, 0, 2, 0, -1, 0, 0);
    applyStimulus(1, 1, 0, 3, 100, 0, 0);
    applyStimulus(2, 1, 1, 0, 100, 0, 0);
    applyStimulus(1, 2, 3, 2, 100, 0, 0);
    applyStimulus(1, 0, 5, 0, 100, 0, 2);
    applyStimulus(0, 0, 0, 0, 100, 0, 0);
    applyStimulus(7, 0, 0, 0, 100, 0, 0);
    applyStimulus(3, 0, 15, 0, 100, 0, 0);

    for (int n = 0; n < 80; n++) begin
      applyStimulus(int'($urandom_range(7)), int'($urandom_range(2)), int'($urandom_range(15)),
                    int'($urandom_range(5)), 70, 25, 0);
    end

    applyStimulus(2, 3, 0, 0, 100, 0, 0);
    holdHalt();
    checkOutput("scoreboard_drained_before_reset", sb.size(), 0);
    doReset();
    checkResetMidWrite();
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
